reg_file: RTL and testbench
===========================

// Module: reg_file
//
// PURPOSE
//   32 x 32-bit integer register file for the RISC-V pipelined core (decode stage).
//   Two asynchronous read ports (rs1/rs2), one synchronous write port (rd, written from writeback).
//   Register x0 is hardwired to zero.
//
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   ADDR_WIDTH  5   register address width; depth = 2**ADDR_WIDTH (32)
//
// PORTS
//   clk    in   1           clock; all writes on rising edge
//   reset  in   1           asynchronous, active-low reset (0 = reset asserted)
//   A1     in   ADDR_WIDTH  read port 1 address (rs1)
//   A2     in   ADDR_WIDTH  read port 2 address (rs2)
//   A3     in   ADDR_WIDTH  write address (rd)
//   WD3    in   DATA_WIDTH  write data
//   WE3    in   1           write enable, active-high
//   RD1    out  DATA_WIDTH  read data for A1
//   RD2    out  DATA_WIDTH  read data for A2
//
// BEHAVIOUR
//   - Reset: reset low clears all registers to 0 immediately, independent of clk.
//     RD1/RD2 = 0 for every address while in reset and after release until written.
//   - Reset beats write: a write attempted while reset is low is dropped.
//   - Write: at posedge clk, if reset high, WE3=1 and A3!=0, then reg[A3] <= WD3. One-cycle latency.
//   - WE3=0: no register changes, whatever A3/WD3 are.
//   - x0: never written, even with WE3=1. RD1/RD2 for address 0 are always 0 (forced on the read path).
//   - Read: combinational. RD1 = reg[A1], RD2 = reg[A2]. Zero latency.
//     Both ports may read the same address at once, including A3's address.
//   - Read-during-write (macro off): a read of A3 returns the old value until the edge and the new value after it.
//   - No X propagation from storage: all entries are defined from reset.
//
// CONFIGURATION
//   RF_BYPASS_EN defined: write-through forwarding.
//     If WE3=1, A3!=0 and A1==A3, RD1 = WD3 combinationally, before the edge. RD2 is the same with A2.
//     Lets the decode stage see the value being written back in the same cycle.
//   RF_BYPASS_EN undefined: pure array read as above, no forwarding path.
//   x0 stays zero in both configurations.
//
// STRUCTURE
//   - Package reg_file_pkg:
//     - constants XLEN=32, REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0
//     - typedefs reg_addr_t (logic [4:0]) and reg_data_t (logic [31:0])
//   - Storage: reg_data_t array [NUM_REGS-1:1] in one always_ff with async reset. No entry for x0.
//   - Sub-module reg_file_read_port, instantiated twice:
//     - inputs: address, array view, and write-side signals for the bypass
//     - handles the zero-register force and the optional RF_BYPASS_EN forward.
//
// TESTING
//   1. Assert reset (low) for 10 ns, release, sweep A1=A2=0..31 -> RD1=RD2=0 at every address.
//   2. WE3=1, for i=0..31 drive A1=A2=A3=i, WD3=i, one clock each.
//      -> after each edge RD1=RD2=i; x0 reads 0.
//   3. WE3=0, for i=0..31 drive A3=i, WD3=100 -> RD1=RD2 still i; no register becomes 100.
//   4. WE3=1, A3=0, WD3=1, clock -> RD1=RD2=0 with A1=A2=0.
//   5. Write 0xDEADBEEF to x5, then pull reset low mid-cycle, no clock edge -> RD1(A1=5)=0 immediately.
//   6. A1=7, A2=9 with different stored values -> RD1/RD2 independent.
//      RF_BYPASS_EN: WE3=1, A3=A1=7, WD3=0x55 -> RD1=0x55 before the edge.
//      Without the macro: RD1 shows the old x7 value until the edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
// Optional write-through forwarding is enabled with the RF_BYPASS_EN macro.
package reg_file_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       reg_data_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: array lookup, x0 forced to zero and, with RF_BYPASS_EN,
// forwarding of the in-flight write data.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = XLEN,
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wa,
   input  logic [DATA_WIDTH-1:0] wd,
   output logic [DATA_WIDTH-1:0] data
);

   localparam logic [ADDR_WIDTH-1:0] Zero = ADDR_WIDTH'(ZERO_REG);

`ifdef RF_BYPASS_EN
   always_comb begin
      data = regs[addr];
      if (we && (wa != Zero) && (wa == addr)) data = wd;
      if (addr == Zero) data = '0;
   end
`else
   logic unused_wr;
   assign unused_wr = ^{we, wa, wd};

   always_comb begin
      data = regs[addr];
      if (addr == Zero) data = '0;
   end
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero. Define RF_BYPASS_EN for write-through forwarding to the read ports.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = XLEN,
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   input  logic                  WE3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);

   localparam int unsigned Depth = 2**ADDR_WIDTH;

   // No storage for x0; the read view supplies a constant zero in its slot.
   logic [DATA_WIDTH-1:0] regs_q [Depth-1:1];
   logic [DATA_WIDTH-1:0] view   [Depth];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < Depth; i++) regs_q[i] <= '0;
      end else if (WE3 && (A3 != '0)) begin
         regs_q[A3] <= WD3;
      end
   end

   always_comb begin
      view[0] = '0;
      for (int i = 1; i < Depth; i++) view[i] = regs_q[i];
   end

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd1 (
      .addr (A1),
      .regs (view),
      .we   (WE3),
      .wa   (A3),
      .wd   (WD3),
      .data (RD1)
   );

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd2 (
      .addr (A2),
      .regs (view),
      .we   (WE3),
      .wa   (A3),
      .wd   (WD3),
      .data (RD2)
   );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; forwarding expectations follow RF_BYPASS_EN.
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic [4:0]  A1, A2, A3;
   logic [31:0] WD3;
   logic        WE3;
   logic [31:0] RD1, RD2;

   int n_cmp = 0;
   int n_bad = 0;

   reg_file dut (
      .clk   (clk),
      .reset (reset),
      .A1    (A1),
      .A2    (A2),
      .A3    (A3),
      .WD3   (WD3),
      .WE3   (WE3),
      .RD1   (RD1),
      .RD2   (RD2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_fwd;
   logic [31:0] exp_v;

   initial begin
      reset = 1'b0;
      A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WE3 = 1'b0;

      // 1. reset: everything reads zero during and after reset
      #1;
      A1 = 5'd3; A2 = 5'd31; #1;
      check("in_reset_rd1", RD1, 32'h0);
      check("in_reset_rd2", RD2, 32'h0);
      #8;
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(i); #1;
         check("post_reset_rd1", RD1, 32'h0);
         check("post_reset_rd2", RD2, 32'h0);
      end

      // 2. write i to every register, read it back through both ports
      WE3 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(i); A3 = 5'(i); WD3 = 32'(i);
         tick();
         exp_v = (i == 0) ? 32'h0 : 32'(i);
         check("wr_rd1", RD1, exp_v);
         check("wr_rd2", RD2, exp_v);
      end

      // 3. write enable low: nothing changes
      WE3 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(i); A3 = 5'(i); WD3 = 32'd100;
         tick();
         exp_v = (i == 0) ? 32'h0 : 32'(i);
         check("we0_rd1", RD1, exp_v);
         check("we0_rd2", RD2, exp_v);
      end

      // 4. x0 ignores writes
      WE3 = 1'b1; A3 = 5'd0; WD3 = 32'd1; A1 = 5'd0; A2 = 5'd0;
      #1;
      check("x0_pre_rd1", RD1, 32'h0);
      tick();
      check("x0_rd1", RD1, 32'h0);
      check("x0_rd2", RD2, 32'h0);

      // 5. async reset mid-cycle clears x5 without a clock edge; reset beats write
      A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd6;
      tick();
      WE3 = 1'b0;
      #1;
      check("x5_written", RD1, 32'hDEADBEEF);
      check("x6_kept", RD2, 32'd6);
      reset = 1'b0;
      #1;
      check("async_rst_x5", RD1, 32'h0);
      check("async_rst_x6", RD2, 32'h0);
      WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h12345678;
      tick();
      WE3 = 1'b0;
      #1;
      check("rst_beats_wr", RD1, 32'h0);
      reset = 1'b1;
      #1;
      check("after_release", RD1, 32'h0);

      // 6. independent ports, then read-during-write on x7
      WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h77;
      tick();
      A3 = 5'd9; WD3 = 32'h99;
      tick();
      WE3 = 1'b0; A1 = 5'd7; A2 = 5'd9;
      #1;
      check("indep_rd1", RD1, 32'h77);
      check("indep_rd2", RD2, 32'h99);
`ifdef RF_BYPASS_EN
      exp_fwd = 32'h55;
`else
      exp_fwd = 32'h77;
`endif
      WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h55;
      #1;
      check("rdw_pre_rd1", RD1, exp_fwd);
      check("rdw_pre_rd2", RD2, 32'h99);
      A2 = 5'd7;
      #1;
      check("rdw_pre_rd2_same", RD2, exp_fwd);
      tick();
      WE3 = 1'b0;
      #1;
      check("rdw_post_rd1", RD1, 32'h55);
      check("rdw_post_rd2", RD2, 32'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
